// File: rtl/multi_timer_if.sv
// Register-bus interface between the CPU bridge device port and multi_timer.
// The bridge drives addr/we/wd; the timer returns combinational rd and the IRQ vector.
interface multi_timer_if #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
);
    logic [CH_BITS+1:0] addr;
    logic               we;
    logic [31:0]        wd;
    logic [31:0]        rd;
    logic [NUM_CH-1:0]  irq;

    modport master (output addr, we, wd, input rd, irq);
    modport slave  (input addr, we, wd, output rd, irq);
endinterface

// File: rtl/multi_timer.sv
// N-channel countdown timer with one-shot/auto-reload modes, sticky pending flags
// and a masked per-channel IRQ vector, accessed through word registers {ch, reg}.
module multi_timer #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int WIDTH   = 32
) (
    input  logic          clk,
    input  logic          rst,
    multi_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CNT  = 2'b01,
        INT  = 2'b10
    } state_t;

    localparam logic [1:0]       REG_CTRL    = 2'd0;
    localparam logic [1:0]       REG_PRESET  = 2'd1;
    localparam logic [1:0]       REG_COUNT   = 2'd2;
    localparam logic [1:0]       REG_STATUS  = 2'd3;
    localparam logic [1:0]       MODE_RELOAD = 2'b01;
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    logic [NUM_CH-1:0] en_q;
    logic [1:0]        mode_q    [NUM_CH];
    logic [NUM_CH-1:0] im_q;
    logic [WIDTH-1:0]  preset_q  [NUM_CH];
    logic [WIDTH-1:0]  count_q   [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    state_t            state_q   [NUM_CH];

    state_t            state_d   [NUM_CH];
    logic [WIDTH-1:0]  count_d   [NUM_CH];
    logic [NUM_CH-1:0] set_pending;
    logic [NUM_CH-1:0] clr_en;

    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_preset;
    logic [NUM_CH-1:0] wr_status;

    logic [CH_BITS-1:0] ch_sel;
    logic [1:0]         reg_sel;
    logic [31:0]        rd_word;
    logic [NUM_CH-1:0]  irq_vec;
    logic               unused_ok;

    assign ch_sel  = bus.addr[CH_BITS+1:2];
    assign reg_sel = bus.addr[1:0];

    // Upper write-data bits are intentionally ignored by every register.
    assign unused_ok = &{1'b0, bus.wd};

    // Channel selects beyond NUM_CH never match, so their writes vanish and reads return 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ctrl[i]   = 1'b0;
            wr_preset[i] = 1'b0;
            wr_status[i] = 1'b0;
            if (bus.we && (ch_sel == CH_BITS'(i))) begin
                wr_ctrl[i]   = (reg_sel == REG_CTRL);
                wr_preset[i] = (reg_sel == REG_PRESET);
                wr_status[i] = (reg_sel == REG_STATUS);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every output of this block is defaulted before the case so no path
            // leaves a signal unassigned, which would otherwise infer a latch.
            state_d[i]     = state_q[i];
            count_d[i]     = count_q[i];
            set_pending[i] = 1'b0;
            clr_en[i]      = 1'b0;
            unique case (state_q[i])
                IDLE: begin
                    if (en_q[i]) begin
                        count_d[i] = preset_q[i];
                        state_d[i] = CNT;
                    end
                end
                CNT: begin
                    if (!en_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (count_q[i] > ONE) begin
                        count_d[i] = count_q[i] - ONE;
                    end else begin
                        // A preset of 0 lands here on the first count cycle, same as 1.
                        count_d[i]     = '0;
                        set_pending[i] = 1'b1;
                        state_d[i]     = INT;
                    end
                end
                INT: begin
                    if (mode_q[i] == MODE_RELOAD) begin
                        count_d[i] = preset_q[i];
                        state_d[i] = CNT;
                    end else begin
                        clr_en[i]  = 1'b1;
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these per-channel arrays are small register banks, not RAM, and
            // software relies on known values, so every entry is reset.
            for (int i = 0; i < NUM_CH; i++) begin
                en_q[i]      <= 1'b0;
                mode_q[i]    <= 2'b00;
                im_q[i]      <= 1'b0;
                preset_q[i]  <= '0;
                count_q[i]   <= '0;
                pending_q[i] <= 1'b0;
                state_q[i]   <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // NOTE: non-blocking assignments here so every channel updates from
                // pre-edge values regardless of statement order.
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];

                // A software CTRL write beats the hardware EN clear at the same edge.
                if (wr_ctrl[i]) begin
                    en_q[i]   <= bus.wd[0];
                    mode_q[i] <= bus.wd[2:1];
                    im_q[i]   <= bus.wd[3];
                end else if (clr_en[i]) begin
                    en_q[i] <= 1'b0;
                end

                if (wr_preset[i]) begin
                    preset_q[i] <= bus.wd[WIDTH-1:0];
                end

                // Hardware set beats a software clear at the same edge.
                if (set_pending[i]) begin
                    pending_q[i] <= 1'b1;
                end else if (wr_status[i] && bus.wd[0]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_BITS'(i)) begin
                unique case (reg_sel)
                    REG_CTRL:   rd_word[3:0]       = {im_q[i], mode_q[i], en_q[i]};
                    REG_PRESET: rd_word[WIDTH-1:0] = preset_q[i];
                    REG_COUNT:  rd_word[WIDTH-1:0] = count_q[i];
                    REG_STATUS: rd_word[2:0]       = {state_q[i], pending_q[i]};
                    default:    rd_word            = '0;
                endcase
            end
        end
    end

    // Built from registers only, so async reset drops irq without waiting for clk.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            irq_vec[i] = pending_q[i] & im_q[i];
        end
    end

    assign bus.rd  = rd_word;
    assign bus.irq = irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboarded testbench for multi_timer: directed scenarios plus random register traffic,
// with expectations from an edge-timeline reference model of each channel.
module tb_multi_timer;

    localparam int NUM_CH  = 3;
    localparam int CH_BITS = 2;
    localparam int WIDTH   = 16;
    localparam int NSLOT   = 4;
    localparam int unsigned MASK = (1 << WIDTH) - 1;
    localparam int R_CTRL = 0, R_PRESET = 1, R_COUNT = 2, R_STATUS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_timer_if #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) bus ();

    multi_timer #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel is described by its load edge and loaded value;
    // count, pending time and state follow from edge arithmetic.
    bit          m_en   [NSLOT];
    bit [1:0]    m_mode [NSLOT];
    bit          m_im   [NSLOT];
    int unsigned m_preset[NSLOT];
    int unsigned m_count[NSLOT];
    bit          m_pend [NSLOT];
    bit          m_run  [NSLOT];
    int          m_load [NSLOT];
    int unsigned m_p0   [NSLOT];
    int          edge_n = 0;

    function automatic int fire_edge(int c);
        return m_load[c] + ((m_p0[c] == 0) ? 1 : int'(m_p0[c]));
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NSLOT; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_preset[c] = 0;
            m_count[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_load[c] = 0; m_p0[c] = 0;
        end
    endfunction

    function automatic void model_load(int c, int e);
        m_run[c]   = 1;
        m_load[c]  = e;
        m_p0[c]    = m_preset[c];
        m_count[c] = m_preset[c];
    endfunction

    function automatic void model_step(bit w, logic [3:0] a, logic [31:0] d);
        bit fired[NSLOT];
        int e, c;
        edge_n++;
        e = edge_n;
        for (int i = 0; i < NUM_CH; i++) begin
            fired[i] = 0;
            if (!m_run[i]) begin
                if (m_en[i]) model_load(i, e);
            end else if (e - 1 == fire_edge(i)) begin
                if (m_mode[i] == 2'b01) model_load(i, e);
                else begin m_en[i] = 0; m_run[i] = 0; end
            end else if (!m_en[i]) begin
                m_run[i] = 0;
            end else if (e - m_load[i] < fire_edge(i) - m_load[i]) begin
                m_count[i] = m_p0[i] - int'(e - m_load[i]);
            end else begin
                m_count[i] = 0;
                m_pend[i]  = 1;
                fired[i]   = 1;
            end
        end
        c = int'(a[3:2]);
        if (w && c < NUM_CH) begin
            case (int'(a[1:0]))
                R_CTRL:   begin m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3]; end
                R_PRESET: m_preset[c] = d & MASK;
                R_STATUS: if (d[0] && !fired[c]) m_pend[c] = 0;
                default:  ;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_read(logic [3:0] a);
        int c;
        logic [1:0] st;
        c = int'(a[3:2]);
        if (c >= NUM_CH) return 32'h0;
        st = !m_run[c] ? 2'b00 : ((edge_n == fire_edge(c)) ? 2'b10 : 2'b01);
        case (int'(a[1:0]))
            R_CTRL:   return {28'h0, m_im[c], m_mode[c], m_en[c]};
            R_PRESET: return m_preset[c];
            R_COUNT:  return m_count[c];
            default:  return {29'h0, st, m_pend[c]};
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] model_irq();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pend[c] & m_im[c];
        return v;
    endfunction

    function automatic logic [3:0] ad(int ch, int r);
        return 4'((ch << 2) | r);
    endfunction

    // Scoreboard: the driver queues read expectations, the monitor consumes them.
    logic [31:0] exp_q[$];
    bit          rd_req = 0;

    always @(negedge clk) begin
        check("irq", 32'(bus.irq), 32'(model_irq()));
        if (rd_req) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_queue: read presented with no expectation queued at %0t", $time);
            end else begin
                check($sformatf("rd addr=%0h", bus.addr), bus.rd, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input bit w, input logic [3:0] a, input logic [31:0] d);
        bus.we   = w;
        bus.addr = a;
        bus.wd   = d;
        @(posedge clk);
        model_step(w, a, d);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        tick(1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 4'h0, 32'h0);
    endtask

    task automatic rd_exp(input logic [3:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        rd_req = 1;
        tick(1'b0, a, 32'h0);
        rd_req = 0;
    endtask

    task automatic rd_model(input logic [3:0] a);
        rd_exp(a, model_read(a));
    endtask

    initial begin
        int exp_cnt[7];
        logic [3:0]  a;
        logic [31:0] d;
        int r;

        exp_cnt = '{0, 5, 4, 3, 2, 1, 0};
        bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #1 check("reset irq", 32'(bus.irq), 32'h0);
        for (int i = 0; i < 16; i++) begin
            bus.addr = 4'(i);
            #1 check($sformatf("reset rd addr=%0h", i), bus.rd, 32'h0);
        end
        @(negedge clk) rst = 1'b0;

        // One-shot, ch0, PRESET=5
        wr(ad(0, R_PRESET), 32'd5);
        wr(ad(0, R_CTRL), 32'h9);
        for (int i = 0; i < 7; i++) rd_exp(ad(0, R_COUNT), exp_cnt[i]);
        rd_exp(ad(0, R_CTRL), 32'h8);
        rd_exp(ad(0, R_STATUS), 32'h1);
        wr(ad(0, R_STATUS), 32'h1);
        rd_exp(ad(0, R_STATUS), 32'h0);

        // Auto-reload, ch1, PRESET=3: clear coinciding with a set leaves pending
        wr(ad(1, R_PRESET), 32'd3);
        wr(ad(1, R_CTRL), 32'hB);
        idle(3);
        wr(ad(1, R_STATUS), 32'h1);
        rd_exp(ad(1, R_STATUS), 32'h5);
        wr(ad(1, R_STATUS), 32'h1);
        rd_exp(ad(1, R_STATUS), 32'h2);
        rd_exp(ad(1, R_STATUS), 32'h2);
        rd_exp(ad(1, R_STATUS), 32'h5);
        wr(ad(1, R_CTRL), 32'h0);
        idle(2);

        // Mask then unmask, ch2
        wr(ad(2, R_PRESET), 32'd2);
        wr(ad(2, R_CTRL), 32'h1);
        idle(4);
        rd_exp(ad(2, R_STATUS), 32'h1);
        wr(ad(2, R_CTRL), 32'h9);
        wr(ad(2, R_STATUS), 32'h1);
        rd_model(ad(2, R_STATUS));
        idle(4);
        wr(ad(2, R_CTRL), 32'h0);
        wr(ad(2, R_STATUS), 32'h1);

        // Stop at COUNT=7, resume reloads PRESET
        wr(ad(0, R_PRESET), 32'd10);
        wr(ad(0, R_CTRL), 32'h1);
        idle(3);
        wr(ad(0, R_CTRL), 32'h0);
        idle(1);
        rd_exp(ad(0, R_COUNT), 32'd7);
        rd_exp(ad(0, R_STATUS), 32'h0);
        wr(ad(0, R_CTRL), 32'h1);
        idle(1);
        rd_exp(ad(0, R_COUNT), 32'd10);
        wr(ad(0, R_CTRL), 32'h0);
        idle(2);

        // Decode, width truncation, read-only COUNT, unused CTRL bits
        wr(ad(3, R_PRESET), 32'h1234);
        for (int c = 0; c < NUM_CH; c++) rd_model(ad(c, R_PRESET));
        for (int i = 0; i < 4; i++) rd_exp(ad(3, i), 32'h0);
        wr(ad(0, R_COUNT), 32'hFFFF);
        rd_model(ad(0, R_COUNT));
        wr(ad(1, R_PRESET), 32'hABCD_1234);
        rd_exp(ad(1, R_PRESET), 32'h0000_1234);
        wr(ad(1, R_CTRL), 32'hFFFF_FFF8);
        rd_exp(ad(1, R_CTRL), 32'h8);
        wr(ad(1, R_CTRL), 32'h0);
        wr(ad(1, R_PRESET), 32'd2);

        // Random register traffic
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 9);
            a = 4'($urandom_range(0, 15));
            if (r < 4) begin
                idle(1);
            end else if (r < 7) begin
                rd_model(a);
            end else begin
                case (int'(a[1:0]))
                    R_CTRL:   d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
                    R_PRESET: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
                    default:  d = $urandom;
                endcase
                wr(a, d);
            end
        end

        // Async reset while counting with irq high
        wr(ad(0, R_PRESET), 32'd6);
        wr(ad(0, R_CTRL), 32'hB);
        idle(10);
        check("pre-reset irq0", 32'(bus.irq[0]), 32'h1);
        #2 rst = 1'b1;
        model_reset();
        #1 check("rst irq", 32'(bus.irq), 32'h0);
        bus.addr = ad(0, R_COUNT);
        #1 check("rst count0", bus.rd, 32'h0);
        bus.addr = ad(0, R_CTRL);
        #1 check("rst ctrl0", bus.rd, 32'h0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        idle(5);
        rd_exp(ad(0, R_COUNT), 32'h0);
        rd_exp(ad(0, R_STATUS), 32'h0);
        rd_exp(ad(0, R_CTRL), 32'h0);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_queue: %0d expectations never consumed", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
